// File: rtl/apb_bcd_alu.sv
// apb_bcd_alu: APB slave running digit-serial BCD add/subtract, one digit per PCLK.
// Optional interrupt output and CTRL.IE bit enabled by defining APB_BCD_IRQ_EN.
module apb_bcd_alu #(
  parameter int unsigned DIGITS    = 8,
  parameter logic [7:0]  CTRL_ADDR = 8'h00,
  parameter logic [7:0]  OPA_ADDR  = 8'h04,
  parameter logic [7:0]  OPB_ADDR  = 8'h08,
  parameter logic [7:0]  RES_ADDR  = 8'h0C,
  parameter logic [7:0]  STAT_ADDR = 8'h10
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
`ifdef APB_BCD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t          state;
  logic [DW-1:0]   opa, opb, result;
  logic [DW-1:0]   a_sh, b_sh, acc;
  logic [IW-1:0]   idx;
  logic            mode, mode_s, cy, inv;
  logic            done, carry, invalid;
  logic            ie;
  logic            busy;

  logic            access_c, wr_ok_c, start_c, slverr_c;
  logic            hit_ctrl_c, hit_opa_c, hit_opb_c, hit_res_c, hit_stat_c;
  logic [31:0]     rdata_c;
  logic [3:0]      a_d_c, b_d_c, dig_c;
  logic [4:0]      sum5_c, dif5_c;
  logic            cout_c, bad_c;
  logic            unused_c;

  assign busy     = (state != S_IDLE);
  assign unused_c = ^{PADDR[31:8], PWDATA};

  // Address decode, error classification and read mux for the current access
  always_comb begin
    hit_ctrl_c = (PADDR[7:0] == CTRL_ADDR);
    hit_opa_c  = (PADDR[7:0] == OPA_ADDR);
    hit_opb_c  = (PADDR[7:0] == OPB_ADDR);
    hit_res_c  = (PADDR[7:0] == RES_ADDR);
    hit_stat_c = (PADDR[7:0] == STAT_ADDR);
    access_c   = PSEL && PENABLE && !PREADY;
    slverr_c   = !(hit_ctrl_c || hit_opa_c || hit_opb_c || hit_res_c || hit_stat_c)
               || (PWRITE && (hit_res_c || hit_stat_c))
               || (PWRITE && busy && (hit_ctrl_c || hit_opa_c || hit_opb_c));
    wr_ok_c    = access_c && PWRITE && !slverr_c;
    start_c    = wr_ok_c && hit_ctrl_c && PWDATA[0];
    rdata_c    = '0;
    if (hit_ctrl_c)      rdata_c = {29'd0, ie, mode, 1'b0};
    else if (hit_opa_c)  rdata_c = 32'(opa);
    else if (hit_opb_c)  rdata_c = 32'(opb);
    else if (hit_res_c)  rdata_c = 32'(result);
    else if (hit_stat_c) rdata_c = {28'd0, invalid, carry, done, busy};
  end

  // One BCD digit step on the low nibbles of the operand shifters
  always_comb begin
    a_d_c  = a_sh[3:0];
    b_d_c  = b_sh[3:0];
    sum5_c = 5'(a_d_c) + 5'(b_d_c) + 5'(cy);
    dif5_c = 5'(a_d_c) - 5'(b_d_c) - 5'(cy);
    dig_c  = 4'd0;
    cout_c = 1'b0;
    if (mode_s) begin
      if (sum5_c > 5'd9) begin
        dig_c  = 4'(sum5_c - 5'd10);
        cout_c = 1'b1;
      end else begin
        dig_c  = sum5_c[3:0];
      end
    end else begin
      if (dif5_c[4]) begin
        dig_c  = dif5_c[3:0] + 4'd10;
        cout_c = 1'b1;
      end else begin
        dig_c  = dif5_c[3:0];
      end
    end
    bad_c = (a_d_c > 4'd9) || (b_d_c > 4'd9);
  end

  // APB response: one wait state, data/error registered alongside PREADY
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= access_c;
      PSLVERR <= access_c && slverr_c;
      PRDATA  <= (access_c && !PWRITE) ? rdata_c : '0;
    end
  end

  // Register file writes and the IDLE/CALC/FIN digit-serial engine
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= S_IDLE;
      opa     <= '0;
      opb     <= '0;
      result  <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      idx     <= '0;
      mode    <= 1'b0;
      mode_s  <= 1'b0;
      cy      <= 1'b0;
      inv     <= 1'b0;
      done    <= 1'b0;
      carry   <= 1'b0;
      invalid <= 1'b0;
    end else begin
      if (wr_ok_c && hit_opa_c)  opa  <= PWDATA[DW-1:0];
      if (wr_ok_c && hit_opb_c)  opb  <= PWDATA[DW-1:0];
      if (wr_ok_c && hit_ctrl_c) mode <= PWDATA[1];
      case (state)
        S_IDLE: begin
          if (start_c) begin
            state  <= S_CALC;
            a_sh   <= opa;
            b_sh   <= opb;
            acc    <= '0;
            mode_s <= PWDATA[1];
            idx    <= '0;
            cy     <= 1'b0;
            inv    <= 1'b0;
            done   <= 1'b0;
          end
        end
        S_CALC: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          acc  <= (acc >> 4) | (DW'(dig_c) << (DW - 4));
          cy   <= cout_c;
          inv  <= inv | bad_c;
          idx  <= idx + IW'(1);
          if (idx == IW'(DIGITS - 1)) state <= S_FIN;
        end
        S_FIN: begin
          result  <= acc;
          carry   <= cy;
          invalid <= inv;
          done    <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef APB_BCD_IRQ_EN
  // Interrupt enable bit and registered done interrupt, dropped on START
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_ok_c && hit_ctrl_c) ie <= PWDATA[2];
      if (start_c) irq <= 1'b0;
      else         irq <= done && ie;
    end
  end
`else
  assign ie = 1'b0;
`endif

endmodule

// File: doc/apb_bcd_alu.md
Name: apb_bcd_alu

Overview:
- Parametrised APB slave that performs BCD subtraction or addition on operands of DIGITS digits.
- Sequential digit-serial engine: processes one BCD digit per PCLK cycle, least-significant digit first.
- Provides busy/done/carry/invalid status and a proper wait-stated APB handshake with error reporting.
- Sits on the peripheral APB bus alongside the existing arithmetic peripherals and is software-driven through five registers.

Parameters:
- DIGITS, 8, number of BCD digits per operand/result (legal range 1..8); data width is 4*DIGITS, zero-extended to 32 bits.
- CTRL_ADDR, 8'h00, control register offset.
- OPA_ADDR, 8'h04, operand A register offset.
- OPB_ADDR, 8'h08, operand B register offset.
- RES_ADDR, 8'h0C, result register offset (read-only).
- STAT_ADDR, 8'h10, status register offset (read-only).

Ports:
- PCLK  in  1  single clock; all logic on posedge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  peripheral select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address; only PADDR[7:0] is decoded, upper bits ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error, valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1 at posedge): clears all registers, the FSM goes to IDLE, and PRDATA, PREADY and PSLVERR are driven to 0. Reset mid-calculation aborts the operation with no result written.
- APB handshake:
  - One wait state. PREADY is registered and rises in the cycle after the first PSEL&&PENABLE cycle; it is held high for exactly one cycle, then returns to 0.
  - The write commits, and PRDATA/PSLVERR become valid, in the PREADY=1 cycle.
  - Back-to-back transfers are supported.
- CTRL register:
  - bit0 START is write-1-to-start and self-clearing; it always reads 0.
  - bit1 MODE: 0 = A-B, 1 = A+B. MODE is captured at START; bits [31:3] read 0.
- OPA and OPB: writes store PWDATA[4*DIGITS-1:0]; upper bits are dropped. They read back zero-extended.
- RESULT: updated only on completion. Reads during BUSY return the previous result.
- STATUS fields:
  - bit0 BUSY.
  - bit1 DONE: set on completion, cleared on START.
  - bit2 CARRY: borrow for SUB, carry for ADD.
  - bit3 INVALID: any operand digit >9.
- PSLVERR=1 in each of these cases:
  - Unmapped address: read returns 0, write has no effect.
  - Write to RES or STAT: no effect.
  - Write to CTRL, OPA or OPB while BUSY: ignored, registers unchanged.
- FSM:
  - IDLE --START--> CALC. In the same cycle the engine snapshots the operands, clears the digit index, clears the carry/borrow, and sets BUSY=1, DONE=0.
  - CALC performs one digit per cycle. At index DIGITS-1 it goes to FIN.
  - FIN writes RESULT, sets CARRY/INVALID and DONE, clears BUSY, then goes to IDLE.
  - Latency: BUSY=1 for DIGITS+1 cycles after the START commit cycle. DONE is visible at the next read.
- Digit arithmetic:
  - SUB: d = a - b - bin. If d<0 then d += 10 and bout = 1, else bout = 0.
  - ADD: s = a + b + cin. If s>9 then s -= 10 and cout = 1, else cout = 0.
  - Final borrow=1 means A<B; the result is then the ten's complement (e.g. 3 digits: 123-345 = 778).
  - Invalid digits (>9) are still processed arithmetically modulo 16 and flagged INVALID=1; the result is undefined-but-deterministic.
- A write to CTRL with START=1 while BUSY gets PSLVERR=1 and does not restart the operation.

Optional Feature:
- Macro APB_BCD_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - CTRL bit2 is IE (read/write).
  - irq = DONE && IE, registered, and cleared by START or reset.
- Undefined:
  - No irq port.
  - CTRL bit2 writes are ignored and it reads 0.

Test Plan:
- DIGITS=3: write OPA=0x345, OPB=0x123, CTRL=0x1 -> BUSY for 4 cycles, then RESULT=0x222, STATUS=0x2.
- DIGITS=3: OPA=0x123, OPB=0x345, CTRL=0x1 (SUB) -> RESULT=0x778, STATUS=0x6 (DONE|CARRY).
- DIGITS=3: OPA=0x999, OPB=0x001, CTRL=0x3 (ADD) -> RESULT=0x000, STATUS=0x6.
- DIGITS=3: OPA=0x1A3 -> after completion STATUS bit3=1; read of PADDR=0x14 -> PRDATA=0, PSLVERR=1.
- Write OPB=0x111 while BUSY -> PSLVERR=1, OPB unchanged. PRESET asserted mid-CALC -> STATUS=0, RESULT=0 next cycle, no DONE.
- Every transfer: PREADY high exactly one cycle, one cycle after the PENABLE rise. With APB_BCD_IRQ_EN and IE=1: irq rises after completion and falls on next START.
